tile_bg_engine_v2: RTL and testbench

Pipelined, parametrised tile-map background renderer for the 640x480 VGA path. It replaces the combinational background engine with a fixed-latency pipeline. Features: synchronous tile-map RAM and tile-sheet ROM, independent X/Y scroll with torus wrap-around, and scroll updates applied only at frame boundaries, so there is no tearing. Output feeds the existing sprite/background priority mux alongside the other pixel engines.

---
 rtl/bg_pkg.sv | 17 +
 rtl/bg_scroll_regs.sv | 65 ++++++
 rtl/tile_bg_engine_v2.sv | 109 ++++++++++
 tb/tb_tile_bg_engine_v2.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Shared constants and tile-map word layout for the pipelined background engine.
package bg_pkg;

    localparam int          BG_LATENCY      = 4;
    localparam logic [11:0] TRANSPARENT_DEF = 12'h00F;

    // Tile-map RAM word: sheet column/row of the tile plus flip and enable flags.
    typedef struct packed {
        logic [6:0] rsvd;
        logic       enable;
        logic       yflip;
        logic       xflip;
        logic [2:0] row;
        logic [2:0] col;
    } tile_word_t;

endpackage

// File: rtl/bg_scroll_regs.sv
// Shadow/active scroll registers; shadow values move to active only on frame_start.
module bg_scroll_regs
    import bg_pkg::*;
#(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          frame_start_i,
    input  logic          scroll_wr_i,
    input  logic [XW-1:0] scroll_x_in_i,
    input  logic [YW-1:0] scroll_y_in_i,
    output logic [XW-1:0] scroll_x_o,
    output logic [YW-1:0] scroll_y_o,
    output logic          scroll_pending_o
);

    logic [XW-1:0] shadow_x_q, shadow_x_d, active_x_q, active_x_d;
    logic [YW-1:0] shadow_y_q, shadow_y_d, active_y_q, active_y_d;
    logic          pending_q, pending_d;
    logic          apply;

    // A write coinciding with frame_start applies the old shadow and leaves the new one pending.
    assign apply = frame_start_i & pending_q;

    always_comb begin
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        active_x_d = active_x_q;
        active_y_d = active_y_q;
        pending_d  = pending_q;
        if (apply) begin
            active_x_d = shadow_x_q;
            active_y_d = shadow_y_q;
            pending_d  = 1'b0;
        end
        if (scroll_wr_i) begin
            shadow_x_d = scroll_x_in_i;
            shadow_y_d = scroll_y_in_i;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shadow_x_q <= '0;
            shadow_y_q <= '0;
            active_x_q <= '0;
            active_y_q <= '0;
            pending_q  <= 1'b0;
        end else begin
            shadow_x_q <= shadow_x_d;
            shadow_y_q <= shadow_y_d;
            active_x_q <= active_x_d;
            active_y_q <= active_y_d;
            pending_q  <= pending_d;
        end
    end

    assign scroll_x_o       = active_x_q;
    assign scroll_y_o       = active_y_q;
    assign scroll_pending_o = pending_q;

endmodule

// File: rtl/tile_bg_engine_v2.sv
// Fixed-latency tile-map background renderer: scroll -> map RAM -> sheet ROM -> colour.
module tile_bg_engine_v2
    import bg_pkg::*;
#(
    parameter int                 TILE_W_LOG2     = 4,
    parameter int                 TILE_H_LOG2     = 4,
    parameter int                 MAP_COLS_LOG2   = 6,
    parameter int                 MAP_ROWS_LOG2   = 5,
    parameter int                 SHEET_COLS_LOG2 = 3,
    parameter int                 SHEET_ROWS_LOG2 = 3,
    parameter int                 COLOR_W         = 12,
    parameter logic [COLOR_W-1:0] TRANSPARENT     = COLOR_W'(TRANSPARENT_DEF)
) (
    input  logic                                                          clk_i,
    input  logic                                                          reset_i,
    input  logic                                                          video_on_i,
    input  logic [9:0]                                                    x_i,
    input  logic [9:0]                                                    y_i,
    input  logic                                                          frame_start_i,
    input  logic [MAP_COLS_LOG2+TILE_W_LOG2-1:0]                          scroll_x_in_i,
    input  logic [MAP_ROWS_LOG2+TILE_H_LOG2-1:0]                          scroll_y_in_i,
    input  logic                                                          scroll_wr_i,
    output logic                                                          scroll_pending_o,
    output logic [MAP_COLS_LOG2+MAP_ROWS_LOG2-1:0]                        map_addr_o,
    input  logic [15:0]                                                   map_data_i,
    output logic [SHEET_ROWS_LOG2+TILE_H_LOG2+SHEET_COLS_LOG2+TILE_W_LOG2-1:0] rom_addr_o,
    input  logic [COLOR_W-1:0]                                            rom_data_i,
    output logic                                                          pixel_on_o,
    output logic [COLOR_W-1:0]                                            color_o
);

    localparam int WX_W = MAP_COLS_LOG2 + TILE_W_LOG2;
    localparam int WY_W = MAP_ROWS_LOG2 + TILE_H_LOG2;
    localparam int MA_W = MAP_COLS_LOG2 + MAP_ROWS_LOG2;
    localparam int RA_W = SHEET_ROWS_LOG2 + TILE_H_LOG2 + SHEET_COLS_LOG2 + TILE_W_LOG2;

    logic [WX_W-1:0] scroll_x;
    logic [WY_W-1:0] scroll_y;

    bg_scroll_regs #(.XW(WX_W), .YW(WY_W)) u_scroll (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .frame_start_i    (frame_start_i),
        .scroll_wr_i      (scroll_wr_i),
        .scroll_x_in_i    (scroll_x_in_i),
        .scroll_y_in_i    (scroll_y_in_i),
        .scroll_x_o       (scroll_x),
        .scroll_y_o       (scroll_y),
        .scroll_pending_o (scroll_pending_o)
    );

    logic [WX_W-1:0]                  wx;
    logic [WY_W-1:0]                  wy;
    logic [MA_W-1:0]                  map_addr_q, map_addr_d;
    logic [1:0][TILE_W_LOG2-1:0]      offx_q;
    logic [1:0][TILE_H_LOG2-1:0]      offy_q;
    logic [BG_LATENCY-1:0]            vld_q;
    logic [1:0]                       en_q;
    tile_word_t                       tw;
    logic [TILE_W_LOG2-1:0]           col_pix;
    logic [TILE_H_LOG2-1:0]           row_pix;
    logic [RA_W-1:0]                  rom_addr_q, rom_addr_d;
    logic                             opaque;
    logic                             pixel_on_q;
    logic [COLOR_W-1:0]               color_q, color_d;

    // Torus wrap falls out of truncating the sums to the world width.
    assign wx = WX_W'(x_i) + scroll_x;
    assign wy = WY_W'(y_i) + scroll_y;

    always_comb begin
        map_addr_d = {wy[WY_W-1:TILE_H_LOG2], wx[WX_W-1:TILE_W_LOG2]};
        tw         = tile_word_t'(map_data_i);
        // TILE-1-off is the bitwise complement for power-of-two tiles.
        col_pix    = tw.xflip ? ~offx_q[1] : offx_q[1];
        row_pix    = tw.yflip ? ~offy_q[1] : offy_q[1];
        rom_addr_d = {SHEET_ROWS_LOG2'(tw.row), row_pix, SHEET_COLS_LOG2'(tw.col), col_pix};
        opaque     = vld_q[BG_LATENCY-1] & en_q[1] & (rom_data_i != TRANSPARENT);
        color_d    = opaque ? rom_data_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            map_addr_q <= '0;
            offx_q     <= '0;
            offy_q     <= '0;
            vld_q      <= '0;
            en_q       <= '0;
            rom_addr_q <= '0;
            pixel_on_q <= 1'b0;
            color_q    <= '0;
        end else begin
            map_addr_q <= map_addr_d;
            offx_q     <= {offx_q[0], wx[TILE_W_LOG2-1:0]};
            offy_q     <= {offy_q[0], wy[TILE_H_LOG2-1:0]};
            vld_q      <= {vld_q[BG_LATENCY-2:0], video_on_i};
            en_q       <= {en_q[0], tw.enable};
            rom_addr_q <= rom_addr_d;
            pixel_on_q <= opaque;
            color_q    <= color_d;
        end
    end

    assign map_addr_o = map_addr_q;
    assign rom_addr_o = rom_addr_q;
    assign pixel_on_o = pixel_on_q;
    assign color_o    = color_q;

endmodule

// File: tb/tb_tile_bg_engine_v2.sv
// Directed plus randomized bench for tile_bg_engine_v2 against an arithmetic reference model.
module tb_tile_bg_engine_v2;
    import bg_pkg::*;

    logic        clk = 1'b0;
    logic        rst, video_on, fs, swr;
    logic [9:0]  x, y;
    logic [9:0]  sxi;
    logic [8:0]  syi;
    logic        pend_o;
    logic [10:0] map_addr;
    logic [15:0] map_data;
    logic [13:0] rom_addr;
    logic [11:0] rom_data;
    logic        pixel_on;
    logic [11:0] color;

    always #5 clk = ~clk;

    tile_bg_engine_v2 dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .video_on_i       (video_on),
        .x_i              (x),
        .y_i              (y),
        .frame_start_i    (fs),
        .scroll_x_in_i    (sxi),
        .scroll_y_in_i    (syi),
        .scroll_wr_i      (swr),
        .scroll_pending_o (pend_o),
        .map_addr_o       (map_addr),
        .map_data_i       (map_data),
        .rom_addr_o       (rom_addr),
        .rom_data_i       (rom_data),
        .pixel_on_o       (pixel_on),
        .color_o          (color)
    );

    logic [15:0] map_mem [2048];
    logic [11:0] rom_mem [16384];

    // Synchronous memories: data valid one cycle after the address.
    always @(posedge clk) begin
        map_data <= map_mem[map_addr];
        rom_data <= rom_mem[rom_addr];
    end

    typedef struct {
        bit          on;
        logic [11:0] col;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          act_x = 0, act_y = 0, sh_x = 0, sh_y = 0;
    bit          pend_m = 0;
    bit          started = 0;
    logic [10:0] map_exp = '0;

    function automatic void ref_pix(input int xx, input int yy, input bit von,
                                    input int sx, input int sy,
                                    output bit on, output logic [11:0] c,
                                    output logic [10:0] ma);
        int          wx, wy, idx, tc, tr, cp, rp;
        logic [15:0] w;
        logic [11:0] t;
        wx  = (xx + sx) % 1024;
        wy  = (yy + sy) % 512;
        idx = (wy / 16) * 64 + (wx / 16);
        w   = map_mem[idx];
        tc  = int'(w) % 8;
        tr  = (int'(w) / 8) % 8;
        cp  = tc * 16 + (w[6] ? 15 - (wx % 16) : (wx % 16));
        rp  = tr * 16 + (w[7] ? 15 - (wy % 16) : (wy % 16));
        t   = rom_mem[rp * 128 + cp];
        on  = von && w[8] && (t != 12'h00F);
        c   = on ? t : 12'h000;
        ma  = 11'(idx);
    endfunction

    // One clock: check what is due, then drive this cycle's inputs and predict.
    task automatic cyc(input int xx, input int yy, input bit von, input bit wr,
                       input bit fstart, input bit r, input int sx, input int sy);
        exp_t e;
        @(negedge clk);
        if (q.size() == BG_LATENCY + 1) begin
            e = q.pop_front();
            checks++;
            assert (pixel_on === e.on) else begin
                errors++;
                $error("FAIL pixel_on: got %0b want %0b", pixel_on, e.on);
            end
            checks++;
            assert (color === e.col) else begin
                errors++;
                $error("FAIL color: got %h want %h", color, e.col);
            end
        end
        if (started) begin
            checks++;
            assert (map_addr === map_exp) else begin
                errors++;
                $error("FAIL map_addr: got %0d want %0d", map_addr, map_exp);
            end
            checks++;
            assert (pend_o === pend_m) else begin
                errors++;
                $error("FAIL scroll_pending: got %0b want %0b", pend_o, pend_m);
            end
        end
        x = 10'(xx); y = 10'(yy); video_on = von;
        swr = wr; fs = fstart; rst = r; sxi = 10'(sx); syi = 9'(sy);
        if (r) begin
            foreach (q[i]) begin q[i].on = 0; q[i].col = '0; end
            e.on = 0; e.col = '0; map_exp = '0;
            act_x = 0; act_y = 0; sh_x = 0; sh_y = 0; pend_m = 0;
        end else begin
            ref_pix(xx, yy, von, act_x, act_y, e.on, e.col, map_exp);
            if (fstart && pend_m) begin act_x = sh_x; act_y = sh_y; pend_m = 0; end
            if (wr) begin sh_x = sx % 1024; sh_y = sy % 512; pend_m = 1; end
        end
        q.push_back(e);
        started = 1;
    endtask

    task automatic pix(input int xx, input int yy);
        cyc(xx, yy, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; video_on = 0; fs = 0; swr = 0; x = '0; y = '0; sxi = '0; syi = '0;
        for (int i = 0; i < 2048; i++) map_mem[i] = {7'b0, 9'($urandom)};
        for (int i = 0; i < 16384; i++)
            rom_mem[i] = ($urandom_range(0, 7) == 0) ? 12'h00F : 12'($urandom);
        map_mem[66]            = 16'h0109;
        rom_mem[18 * 128 + 19] = 12'hABC;
        map_mem[0]             = 16'h01C0;
        rom_mem[15 * 128 + 12] = 12'h00F;
        map_mem[2]             = 16'h0112;
        rom_mem[(2 * 16 + 0) * 128 + 2 * 16 + 0] = 12'h5A5;

        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        idle(5);

        pix(35, 18);
        idle(5);
        pix(3, 0);
        idle(5);

        cyc(0, 0, 0, 1, 0, 0, 1020, 0);
        idle(3);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        pix(10, 0);
        idle(5);

        cyc(100, 5, 1, 1, 0, 0, 32, 0);
        pix(200, 7);
        pix(10, 0);
        idle(2);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        pix(0, 0);
        idle(5);

        cyc(0, 0, 0, 1, 0, 0, 64, 16);
        cyc(40, 40, 1, 1, 1, 0, 128, 48);
        pix(40, 40);
        pix(300, 200);
        idle(2);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        pix(40, 40);
        idle(5);

        for (int i = 0; i < 600; i++)
            cyc(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
                bit'($urandom_range(0, 3) != 0),
                bit'($urandom_range(0, 15) == 0),
                bit'($urandom_range(0, 31) == 0),
                bit'($urandom_range(0, 199) == 0),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)));
        idle(BG_LATENCY + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
